// File: rtl/fifo_pkg.sv
// Shared constants for the 8-entry FIFO control core and its output-flag logic.
// Latency: n/a (package). Backpressure: n/a.
// Contents: operation-state encodings and the default geometry (depth, pointer and count widths).
package fifo_pkg;

   // Operation state encodings; 3'b110 and 3'b111 are never produced.
   localparam logic [2:0] ST_INIT   = 3'b000;
   localparam logic [2:0] ST_WRITE  = 3'b001;
   localparam logic [2:0] ST_WR_ERR = 3'b010;
   localparam logic [2:0] ST_NO_OP  = 3'b011;
   localparam logic [2:0] ST_READ   = 3'b100;
   localparam logic [2:0] ST_RD_ERR = 3'b101;

   // Default geometry. The flag logic compares the count against 8 for full,
   // so the depth must stay 8.
   localparam int DEF_DEPTH = 8;
   localparam int DEF_AW    = 3;   // log2(DEF_DEPTH)
   localparam int DEF_CW    = 4;   // holds 0..DEF_DEPTH

endpackage : fifo_pkg

// File: rtl/fifo_ctrl_ns.sv
// Combinational next-state / next-count / strobe decode for fifo_ctrl.
// Latency: 0 cycles (pure combinational). Backpressure: a write at full or a read
//   at empty is refused (no strobe) and reported as WR_ERR / RD_ERR.
// Ports: wr_en/rd_en requests, count = registered occupancy; state_nxt/count_nxt
//   feed the top-level registers, we/re are the register-file strobes.
// Optional feature: FIFO_CTRL_SIMUL_RW_EN lets a simultaneous write+read proceed.
module fifo_ctrl_ns
   import fifo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int CW    = DEF_CW
) (
   input  logic          wr_en,
   input  logic          rd_en,
   input  logic [CW-1:0] count,
   output logic [2:0]    state_nxt,
   output logic [CW-1:0] count_nxt,
   output logic          we,
   output logic          re
);

   logic full;
   logic empty;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Strobe decode: a strobe is only issued when the occupancy allows it.
   always_comb begin
      we = 1'b0;
      re = 1'b0;
      case ({wr_en, rd_en})
         2'b10: we = !full;
         2'b01: re = !empty;
         2'b11: begin
`ifdef FIFO_CTRL_SIMUL_RW_EN
            // Empty degrades to write-only, full degrades to read-only,
            // anything in between moves both pointers.
            we = !full;
            re = !empty;
`else
            we = 1'b0;
            re = 1'b0;
`endif
         end
         default: begin
            we = 1'b0;
            re = 1'b0;
         end
      endcase
   end

   // Next state and next count. The decision does not depend on the current
   // state, so INIT behaves like any other state.
   always_comb begin
      state_nxt = ST_NO_OP;
      count_nxt = count;
      case ({wr_en, rd_en})
         2'b10:   state_nxt = full  ? ST_WR_ERR : ST_WRITE;
         2'b01:   state_nxt = empty ? ST_RD_ERR : ST_READ;
         2'b11: begin
`ifdef FIFO_CTRL_SIMUL_RW_EN
            if (we && !re)
               state_nxt = ST_WRITE;
            else if (re && !we)
               state_nxt = ST_READ;
            else
               state_nxt = ST_NO_OP;
`else
            state_nxt = ST_NO_OP;
`endif
         end
         default: state_nxt = ST_NO_OP;
      endcase

      // Saturation is guaranteed by the strobe decode: we is never set at
      // full and re is never set at empty, so the count cannot wrap.
      case ({we, re})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

endmodule : fifo_ctrl_ns

// File: rtl/fifo_ctrl.sv
// Sequential control core of the 8-entry FIFO: state, occupancy and head/tail pointers.
// Latency: request sampled at edge N, state/data_count/pointers visible after edge N; we/re are same-cycle.
// Backpressure: write at full -> WR_ERR, read at empty -> RD_ERR, no strobe and no pointer move.
// Ports: clk, reset_n (async, active-low), wr_en/rd_en requests; state and data_count
//   (registered, consumed by the flag logic); we/waddr (tail) and re/raddr (head) to the register file.
// Optional feature: define FIFO_CTRL_SIMUL_RW_EN to allow a simultaneous write+read.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW,
   parameter int CW    = DEF_CW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic          rd_en,
   output logic [2:0]    state,
   output logic [CW-1:0] data_count,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic          re,
   output logic [AW-1:0] raddr
);

   logic [2:0]    state_nxt;
   logic [CW-1:0] count_nxt;
   logic          we_dec;
   logic          re_dec;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;

   fifo_ctrl_ns #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_ns (
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .count     (data_count),
      .state_nxt (state_nxt),
      .count_nxt (count_nxt),
      .we        (we_dec),
      .re        (re_dec)
   );

   // The count is 0 during reset so re_dec is already low, but a write
   // request held through reset must not reach the register file.
   assign we    = we_dec & reset_n;
   assign re    = re_dec & reset_n;
   assign waddr = tail;
   assign raddr = head;

   // State and occupancy move together so the flag logic always sees a
   // consistent (operation, count) pair.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_INIT;
         data_count <= '0;
      end else begin
         state      <= state_nxt;
         data_count <= count_nxt;
      end
   end

   // Pointers wrap modulo DEPTH; the explicit compare keeps the wrap correct
   // even if DEPTH were ever not a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (we_dec)
            tail <= (tail == AW'(DEPTH - 1)) ? '0 : tail + AW'(1);
         if (re_dec)
            head <= (head == AW'(DEPTH - 1)) ? '0 : head + AW'(1);
      end
   end

   // Structural invariants checked in simulation.
   a_state_legal : assert property (@(posedge clk) disable iff (!reset_n)
      (state != 3'b110) && (state != 3'b111));

   a_count_range : assert property (@(posedge clk) disable iff (!reset_n)
      data_count <= CW'(DEPTH));

`ifndef FIFO_CTRL_SIMUL_RW_EN
   a_strobe_excl : assert property (@(posedge clk) disable iff (!reset_n)
      !(we && re));
`endif

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus a randomized run
// against an occupancy/operation-count reference model.
module tb_fifo_ctrl;

   localparam logic [2:0] S_INIT   = 3'd0;
   localparam logic [2:0] S_WRITE  = 3'd1;
   localparam logic [2:0] S_WR_ERR = 3'd2;
   localparam logic [2:0] S_NO_OP  = 3'd3;
   localparam logic [2:0] S_READ   = 3'd4;
   localparam logic [2:0] S_RD_ERR = 3'd5;
   localparam int         N        = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [2:0] state;
   logic [3:0] data_count;
   logic       we;
   logic [2:0] waddr;
   logic       re;
   logic [2:0] raddr;

   int checks = 0;
   int errors = 0;

   // Reference model: total accepted writes/reads since reset.
   // Occupancy is their difference; addresses are the totals modulo N.
   int         m_wr;
   int         m_rd;
   int         m_count;
   logic       e_we;
   logic       e_re;
   logic [2:0] e_state;

   always #5 clk = ~clk;

   fifo_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .state      (state),
      .data_count (data_count),
      .we         (we),
      .waddr      (waddr),
      .re         (re),
      .raddr      (raddr)
   );

   task automatic model_clear();
      m_wr    = 0;
      m_rd    = 0;
      m_count = 0;
   endtask

   // Decide what the current request should do, from the rules alone.
   task automatic model_eval(input logic w, input logic r);
      e_we = 1'b0;
      e_re = 1'b0;
      if (w && !r) begin
         if (m_count == N) e_state = S_WR_ERR;
         else begin e_state = S_WRITE; e_we = 1'b1; end
      end else if (r && !w) begin
         if (m_count == 0) e_state = S_RD_ERR;
         else begin e_state = S_READ; e_re = 1'b1; end
      end else if (w && r) begin
`ifdef FIFO_CTRL_SIMUL_RW_EN
         if (m_count == 0) begin e_state = S_WRITE; e_we = 1'b1; end
         else if (m_count == N) begin e_state = S_READ; e_re = 1'b1; end
         else begin e_state = S_NO_OP; e_we = 1'b1; e_re = 1'b1; end
`else
         e_state = S_NO_OP;
`endif
      end else begin
         e_state = S_NO_OP;
      end
   endtask

   task automatic model_commit();
      if (e_we) m_wr++;
      if (e_re) m_rd++;
      m_count = m_wr - m_rd;
   endtask

   // Inputs change on the falling edge, away from the sampling edge.
   task automatic drive(input logic w, input logic r);
      @(negedge clk);
      wr_en = w;
      rd_en = r;
      #1;
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      reset_n = 1'b0;
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      // Reset asserted from time 0 with a write request held.
      wr_en = 1'b1;
      #2;
      checks++; if (state !== S_INIT) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, S_INIT); end
      checks++; if (data_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", data_count); end
      checks++; if (we !== 1'b0 || re !== 1'b0) begin errors++; $display("FAIL reset_strobes got we=%b re=%b exp 0 0", we, re); end
      checks++; if (waddr !== 3'd0 || raddr !== 3'd0) begin errors++; $display("FAIL reset_addr got w=%0d r=%0d exp 0 0", waddr, raddr); end
      @(negedge clk);
      reset_n = 1'b1;
      wr_en   = 1'b0;
      model_clear();
      // Run a few writes, then drop reset between edges.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0);
         model_eval(1'b1, 1'b0);
         edge_settle();
         model_commit();
      end
      @(negedge clk);
      wr_en = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (state !== S_INIT) begin errors++; $display("FAIL midreset_state got %0d exp %0d", state, S_INIT); end
      checks++; if (data_count !== 4'd0) begin errors++; $display("FAIL midreset_count got %0d exp 0", data_count); end
      checks++; if (we !== 1'b0 || re !== 1'b0) begin errors++; $display("FAIL midreset_strobes got we=%b re=%b exp 0 0", we, re); end
      checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL midreset_waddr got %0d exp 0", waddr); end
      edge_settle();
      checks++; if (state !== S_INIT) begin errors++; $display("FAIL held_reset_state got %0d exp %0d", state, S_INIT); end
      // Release with the write still requested: first edge sees count 0.
      @(negedge clk);
      reset_n = 1'b1;
      model_clear();
      edge_settle();
      checks++; if (state !== S_WRITE || data_count !== 4'd1) begin errors++; $display("FAIL post_release got st=%0d cnt=%0d exp st=%0d cnt=1", state, data_count, S_WRITE); end
      checks++; if (waddr !== 3'd1) begin errors++; $display("FAIL post_release_waddr got %0d exp 1", waddr); end
      wr_en = 1'b0;
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < N + 1; i++) begin
         drive(1'b1, 1'b0);
         model_eval(1'b1, 1'b0);
         checks++; if (we !== (i < N)) begin errors++; $display("FAIL fill_we[%0d] got %b exp %b", i, we, (i < N)); end
         checks++; if (waddr !== 3'(i % N)) begin errors++; $display("FAIL fill_waddr[%0d] got %0d exp %0d", i, waddr, i % N); end
         edge_settle();
         model_commit();
         checks++; if (state !== ((i < N) ? S_WRITE : S_WR_ERR)) begin errors++; $display("FAIL fill_state[%0d] got %0d exp %0d", i, state, (i < N) ? S_WRITE : S_WR_ERR); end
         checks++; if (data_count !== 4'((i < N) ? i + 1 : N)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, data_count, (i < N) ? i + 1 : N); end
      end
   endtask

   // Continues from the full FIFO left by test_fill.
   task automatic test_drain();
      for (int i = 0; i < N + 1; i++) begin
         drive(1'b0, 1'b1);
         model_eval(1'b0, 1'b1);
         checks++; if (re !== (i < N)) begin errors++; $display("FAIL drain_re[%0d] got %b exp %b", i, re, (i < N)); end
         checks++; if (raddr !== 3'(i % N)) begin errors++; $display("FAIL drain_raddr[%0d] got %0d exp %0d", i, raddr, i % N); end
         edge_settle();
         model_commit();
         checks++; if (state !== ((i < N) ? S_READ : S_RD_ERR)) begin errors++; $display("FAIL drain_state[%0d] got %0d exp %0d", i, state, (i < N) ? S_READ : S_RD_ERR); end
         checks++; if (data_count !== 4'((i < N) ? N - 1 - i : 0)) begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, data_count, (i < N) ? N - 1 - i : 0); end
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_wrap();
      logic [2:0] tail_seq [6];
      tail_seq = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
      do_reset();
      for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0); edge_settle(); end
      for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1); edge_settle(); end
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0);
         checks++; if (waddr !== tail_seq[i]) begin errors++; $display("FAIL wrap_waddr[%0d] got %0d exp %0d", i, waddr, tail_seq[i]); end
         edge_settle();
      end
      checks++; if (data_count !== 4'd6) begin errors++; $display("FAIL wrap_count got %0d exp 6", data_count); end
      checks++; if (raddr !== 3'd5) begin errors++; $display("FAIL wrap_head got %0d exp 5", raddr); end
      checks++; if (waddr !== 3'd3) begin errors++; $display("FAIL wrap_tail got %0d exp 3", waddr); end
      wr_en = 1'b0;
   endtask

   task automatic test_simul();
      logic       x_we, x_re;
      logic [2:0] x_tail, x_head;
      do_reset();
      for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0); edge_settle(); end
      drive(1'b1, 1'b1);
`ifdef FIFO_CTRL_SIMUL_RW_EN
      x_we = 1'b1; x_re = 1'b1; x_tail = 3'd4; x_head = 3'd1;
`else
      x_we = 1'b0; x_re = 1'b0; x_tail = 3'd3; x_head = 3'd0;
`endif
      checks++; if (we !== x_we || re !== x_re) begin errors++; $display("FAIL simul_strobes got we=%b re=%b exp %b %b", we, re, x_we, x_re); end
      edge_settle();
      checks++; if (state !== S_NO_OP || data_count !== 4'd3) begin errors++; $display("FAIL simul_state got st=%0d cnt=%0d exp st=3 cnt=3", state, data_count); end
      checks++; if (waddr !== x_tail || raddr !== x_head) begin errors++; $display("FAIL simul_ptrs got w=%0d r=%0d exp %0d %0d", waddr, raddr, x_tail, x_head); end
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   // Both requests at the empty and full boundaries.
   task automatic test_simul_edges();
      do_reset();
      drive(1'b1, 1'b1);
      model_eval(1'b1, 1'b1);
      edge_settle();
      model_commit();
      checks++; if (state !== e_state || data_count !== 4'(m_count)) begin errors++; $display("FAIL simul_empty got st=%0d cnt=%0d exp st=%0d cnt=%0d", state, data_count, e_state, m_count); end
      while (m_count < N) begin
         drive(1'b1, 1'b0); model_eval(1'b1, 1'b0); edge_settle(); model_commit();
      end
      drive(1'b1, 1'b1);
      model_eval(1'b1, 1'b1);
      checks++; if (we !== e_we || re !== e_re) begin errors++; $display("FAIL simul_full_strobes got we=%b re=%b exp %b %b", we, re, e_we, e_re); end
      edge_settle();
      model_commit();
      checks++; if (state !== e_state || data_count !== 4'(m_count)) begin errors++; $display("FAIL simul_full got st=%0d cnt=%0d exp st=%0d cnt=%0d", state, data_count, e_state, m_count); end
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_idle();
      do_reset();
      checks++; if (state !== S_INIT) begin errors++; $display("FAIL idle_init got %0d exp %0d", state, S_INIT); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0);
         edge_settle();
         checks++; if (state !== S_NO_OP || data_count !== 4'd0) begin errors++; $display("FAIL idle[%0d] got st=%0d cnt=%0d exp st=3 cnt=0", i, state, data_count); end
      end
   endtask

   task automatic test_random();
      logic w, r;
      int   k;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         k = int'($urandom_range(0, 9));
         // Alternate write-heavy and read-heavy phases to hit both limits.
         if (((i / 40) % 2) == 0) begin w = (k < 7); r = (k >= 5); end
         else begin w = (k >= 7); r = (k < 5) || (k == 9); end
         drive(w, r);
         model_eval(w, r);
         checks++; if (we !== e_we || re !== e_re) begin errors++; $display("FAIL rand_strobes[%0d] got we=%b re=%b exp %b %b", i, we, re, e_we, e_re); end
         checks++; if (waddr !== 3'(m_wr % N) || raddr !== 3'(m_rd % N)) begin errors++; $display("FAIL rand_addr[%0d] got w=%0d r=%0d exp %0d %0d", i, waddr, raddr, m_wr % N, m_rd % N); end
         edge_settle();
         model_commit();
         checks++; if (state !== e_state) begin errors++; $display("FAIL rand_state[%0d] got %0d exp %0d", i, state, e_state); end
         checks++; if (data_count !== 4'(m_count)) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", i, data_count, m_count); end
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simul();
      test_simul_edges();
      test_idle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fifo_ctrl
